rx_flags_counter_file: RTL and testbench
========================================

RX_FLAGS_COUNTER_FILE -- requirements
Module: rx_flags_counter_file

Interface
REQ-001 SHALL have parameter ADDR_WIDTH_RF, default 2, channel address width; channel count N = 2**ADDR_WIDTH_RF.
REQ-002 SHALL have parameter CNT_WIDTH, default 2, per-channel pending-message counter width; MAX = 2**CNT_WIDTH-1.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: rx_write_enable  in  1  message received on channel address_1.
REQ-005 SHALL have ports: address_1  in  ADDR_WIDTH_RF  receive channel.
REQ-006 SHALL have ports: rtr_write_enable  in  1  consume one message from channel address_2.
REQ-007 SHALL have ports: address_2  in  ADDR_WIDTH_RF  read/consume channel.
REQ-008 SHALL have ports: read_data  out  1  flag, count[address_2] != 0.
REQ-009 SHALL have ports: read_count  out  CNT_WIDTH  count[address_2].
REQ-010 SHALL have ports: clear_errors  in  1  clears sticky error bits.
REQ-011 SHALL have ports: overflow  out  1  sticky; underflow  out  1  sticky; any_pending  out  1  OR of all flags.
REQ-012 SHALL, under RX_FLAGS_ARB_EN only, have: next_valid  out  1; next_channel  out  ADDR_WIDTH_RF; next_ack  in  1.

Function
REQ-013 SHALL hold one CNT_WIDTH-bit counter per channel; read_data, read_count, any_pending are combinational from current (pre-edge) state, zero latency.
REQ-014 SHALL, on rx_write_enable alone to channel c with count<MAX, increment count[c] at the next edge.
REQ-015 SHALL, on rx to c with count==MAX and no rtr to c, hold count[c] and set overflow.
REQ-016 SHALL, on rtr_write_enable alone to channel c with count>0, decrement count[c].
REQ-017 SHALL, on rtr to c with count==0 and no rx to c, hold 0 and set underflow.
REQ-018 SHALL, on rx and rtr to the same channel in one cycle, leave count unchanged at any value (0..MAX) with no error set.
REQ-019 SHALL, on rx and rtr to different channels in one cycle, apply both updates independently.
REQ-020 SHALL clear overflow and underflow on clear_errors; an error event in the same cycle wins (bit ends set).

Reset
REQ-021 SHALL, on reset, set all counts to 0, overflow=0, underflow=0, arbiter pointer=0; reset overrides all inputs that cycle.
REQ-022 SHALL drive after reset: read_data=0, read_count=0, any_pending=0, next_valid=0, next_channel=0.

Configuration
REQ-023 SHALL compile in, when macro RX_FLAGS_ARB_EN is defined, a round-robin pending-channel arbiter; without it the next_* ports and pointer SHALL not exist, all else unchanged.
REQ-024 SHALL (arbiter) drive next_valid=any_pending; next_channel=first channel with nonzero count searching upward from pointer with wrap; next_channel=0 when next_valid=0.
REQ-025 SHALL (arbiter) on next_valid && next_ack set pointer to next_channel+1 modulo N; next_ack with next_valid=0 ignored; ack does not change counts.

Structure
REQ-026 SHALL place default ADDR_WIDTH_RF/CNT_WIDTH constants and the error-bit typedef in shared package rx_flags_pkg.
REQ-027 SHALL implement the arbiter as sub-module rr_pending_arbiter (inputs: flag vector, ack; outputs: valid, channel).

Verification
REQ-028 SHALL cover: reset, then 3 rx to ch1 -> read_count=3 at address_2=1, read_data=1, any_pending=1.
REQ-029 SHALL cover: ch1 at 3 (MAX), rx ch1 -> count stays 3, overflow=1; clear_errors -> overflow=0.
REQ-030 SHALL cover: ch2 at 0, rtr ch2 -> count 0, underflow=1; rtr ch2 plus rx ch2 same cycle at count 0 -> count 0, no new error.
REQ-031 SHALL cover: rx ch0 and rtr ch3 (count 1) same cycle -> ch0=1, ch3=0.
REQ-032 SHALL cover (RX_FLAGS_ARB_EN): ch0 and ch2 pending, pointer 0 -> next_channel=0; ack -> next_channel=2; ack -> next_channel=0 (wrap).
REQ-033 SHALL cover: reset asserted mid-traffic with counts 2/3/1/0 and rx active -> all counts 0, errors 0 next cycle.

Source files
------------

// File: rtl/rx_flags_pkg.sv
// Shared defaults and the sticky error-bit type for the receive flag counter file.
package rx_flags_pkg;

  localparam int ADDR_WIDTH_RF_DEFAULT = 2;
  localparam int CNT_WIDTH_DEFAULT     = 2;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_bits_t;

endpackage

// File: rtl/rr_pending_arbiter.sv
// Round-robin pick of the next pending channel, searching upward from a pointer with wrap.
// Instantiated only when RX_FLAGS_ARB_EN is defined.
module rr_pending_arbiter
  import rx_flags_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_RF_DEFAULT,
  localparam int N = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          flags,
  input  logic                  ack,
  output logic                  valid,
  output logic [ADDR_WIDTH-1:0] channel
);

  logic [ADDR_WIDTH-1:0] pointer;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  found;

  // Channel count is a power of two, so pointer+offset wraps for free.
  always_comb begin
    found   = 1'b0;
    channel = '0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = pointer + i[ADDR_WIDTH-1:0];
      if (!found && flags[idx]) begin
        found   = 1'b1;
        channel = idx;
      end
    end
  end

  assign valid = |flags;

  always_ff @(posedge clk) begin
    if (reset) begin
      pointer <= '0;
    end else if (valid && ack) begin
      pointer <= channel + 1'b1;
    end
  end

endmodule

// File: rtl/rx_flags_counter_file.sv
// Per-channel pending-message counters with sticky overflow/underflow errors.
// Optional round-robin next-channel arbiter is compiled in with RX_FLAGS_ARB_EN.
module rx_flags_counter_file
  import rx_flags_pkg::*;
#(
  parameter int ADDR_WIDTH_RF = ADDR_WIDTH_RF_DEFAULT,
  parameter int CNT_WIDTH     = CNT_WIDTH_DEFAULT,
  localparam int N = 2 ** ADDR_WIDTH_RF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_write_enable,
  input  logic [ADDR_WIDTH_RF-1:0] address_1,
  input  logic                     rtr_write_enable,
  input  logic [ADDR_WIDTH_RF-1:0] address_2,
  output logic                     read_data,
  output logic [CNT_WIDTH-1:0]     read_count,
  input  logic                     clear_errors,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     any_pending
`ifdef RX_FLAGS_ARB_EN
  ,
  output logic                     next_valid,
  output logic [ADDR_WIDTH_RF-1:0] next_channel,
  input  logic                     next_ack
`endif
);

  localparam logic [CNT_WIDTH-1:0] MAX = '1;

  logic [CNT_WIDTH-1:0] count      [N];
  logic [CNT_WIDTH-1:0] next_count [N];
  logic [N-1:0]         rx_hit;
  logic [N-1:0]         rtr_hit;
  logic [N-1:0]         flags;
  logic                 ovf_event;
  logic                 unf_event;
  err_bits_t            errors;
  err_bits_t            next_errors;

  // A simultaneous rx and rtr on one channel cancel out, even at 0 or MAX.
  always_comb begin
    rx_hit             = '0;
    rtr_hit            = '0;
    rx_hit[address_1]  = rx_write_enable;
    rtr_hit[address_2] = rtr_write_enable;
    ovf_event          = 1'b0;
    unf_event          = 1'b0;
    for (int i = 0; i < N; i++) begin
      next_count[i] = count[i];
      case ({rx_hit[i], rtr_hit[i]})
        2'b10: begin
          if (count[i] == MAX) ovf_event = 1'b1;
          else                 next_count[i] = count[i] + 1'b1;
        end
        2'b01: begin
          if (count[i] == '0) unf_event = 1'b1;
          else                next_count[i] = count[i] - 1'b1;
        end
        default: ;
      endcase
    end
    next_errors.overflow  = (errors.overflow  & ~clear_errors) | ovf_event;
    next_errors.underflow = (errors.underflow & ~clear_errors) | unf_event;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) count[i] <= '0;
      errors <= '0;
    end else begin
      for (int i = 0; i < N; i++) count[i] <= next_count[i];
      errors <= next_errors;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) flags[i] = |count[i];
  end

  assign read_count  = count[address_2];
  assign read_data   = flags[address_2];
  assign any_pending = |flags;
  assign overflow    = errors.overflow;
  assign underflow   = errors.underflow;

`ifdef RX_FLAGS_ARB_EN
  rr_pending_arbiter #(
    .ADDR_WIDTH(ADDR_WIDTH_RF)
  ) u_arbiter (
    .clk    (clk),
    .reset  (reset),
    .flags  (flags),
    .ack    (next_ack),
    .valid  (next_valid),
    .channel(next_channel)
  );
`endif

endmodule

// File: tb/tb_rx_flags_counter_file.sv
// Directed self-checking bench for rx_flags_counter_file (default 4 channels, MAX=3).
// Arbiter steps are included when RX_FLAGS_ARB_EN is defined.
module tb_rx_flags_counter_file;

  logic       clk;
  logic       reset;
  logic       rx_write_enable;
  logic [1:0] address_1;
  logic       rtr_write_enable;
  logic [1:0] address_2;
  logic       read_data;
  logic [1:0] read_count;
  logic       clear_errors;
  logic       overflow;
  logic       underflow;
  logic       any_pending;
`ifdef RX_FLAGS_ARB_EN
  logic       next_valid;
  logic [1:0] next_channel;
  logic       next_ack;
`endif

  int assertCount = 0;
  int failCount   = 0;

  rx_flags_counter_file #(
    .ADDR_WIDTH_RF(2),
    .CNT_WIDTH    (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .rx_write_enable (rx_write_enable),
    .address_1       (address_1),
    .rtr_write_enable(rtr_write_enable),
    .address_2       (address_2),
    .read_data       (read_data),
    .read_count      (read_count),
    .clear_errors    (clear_errors),
    .overflow        (overflow),
    .underflow       (underflow),
    .any_pending     (any_pending)
`ifdef RX_FLAGS_ARB_EN
    ,
    .next_valid      (next_valid),
    .next_channel    (next_channel),
    .next_ack        (next_ack)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, clock it, then return to idle just after the edge.
  task automatic applyStimulus(input logic rst, input logic rx, input logic [1:0] a1,
                               input logic rtr, input logic [1:0] a2, input logic clr);
    reset            = rst;
    rx_write_enable  = rx;
    address_1        = a1;
    rtr_write_enable = rtr;
    address_2        = a2;
    clear_errors     = clr;
    @(posedge clk);
    #1;
    reset            = 1'b0;
    rx_write_enable  = 1'b0;
    rtr_write_enable = 1'b0;
    clear_errors     = 1'b0;
`ifdef RX_FLAGS_ARB_EN
    next_ack         = 1'b0;
`endif
    #1;
  endtask

  task automatic probe(input logic [1:0] a2);
    address_2 = a2;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset            = 1'b1;
    rx_write_enable  = 1'b0;
    address_1        = 2'd0;
    rtr_write_enable = 1'b0;
    address_2        = 2'd0;
    clear_errors     = 1'b0;
`ifdef RX_FLAGS_ARB_EN
    next_ack         = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;

    probe(2'd1);
    checkOutput("rst_read_data", 32'(read_data), 32'd0);
    checkOutput("rst_read_count", 32'(read_count), 32'd0);
    checkOutput("rst_any_pending", 32'(any_pending), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_underflow", 32'(underflow), 32'd0);
`ifdef RX_FLAGS_ARB_EN
    checkOutput("rst_next_valid", 32'(next_valid), 32'd0);
    checkOutput("rst_next_channel", 32'(next_channel), 32'd0);
`endif

    applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 2'd1, 1'b0);
    checkOutput("rx1_count1", 32'(read_count), 32'd1);
    applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 2'd1, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 2'd1, 1'b0);
    checkOutput("rx1_count3", 32'(read_count), 32'd3);
    checkOutput("rx1_read_data", 32'(read_data), 32'd1);
    checkOutput("rx1_any_pending", 32'(any_pending), 32'd1);

    applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 2'd1, 1'b0);
    checkOutput("ovf_count_hold", 32'(read_count), 32'd3);
    checkOutput("ovf_set", 32'(overflow), 32'd1);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 2'd1, 1'b1);
    checkOutput("ovf_cleared", 32'(overflow), 32'd0);
    applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 2'd1, 1'b1);
    checkOutput("ovf_beats_clear", 32'(overflow), 32'd1);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 2'd1, 1'b1);
    checkOutput("ovf_cleared2", 32'(overflow), 32'd0);

    probe(2'd2);
    checkOutput("ch2_empty_count", 32'(read_count), 32'd0);
    checkOutput("ch2_empty_flag", 32'(read_data), 32'd0);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0);
    checkOutput("unf_count_hold", 32'(read_count), 32'd0);
    checkOutput("unf_set", 32'(underflow), 32'd1);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 2'd2, 1'b1);
    checkOutput("unf_cleared", 32'(underflow), 32'd0);
    applyStimulus(1'b0, 1'b1, 2'd2, 1'b1, 2'd2, 1'b0);
    checkOutput("same_ch_zero_count", 32'(read_count), 32'd0);
    checkOutput("same_ch_zero_unf", 32'(underflow), 32'd0);
    checkOutput("same_ch_zero_ovf", 32'(overflow), 32'd0);

    applyStimulus(1'b0, 1'b1, 2'd3, 1'b0, 2'd3, 1'b0);
    checkOutput("ch3_count1", 32'(read_count), 32'd1);
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b1, 2'd3, 1'b0);
    checkOutput("split_ch3_dec", 32'(read_count), 32'd0);
    probe(2'd0);
    checkOutput("split_ch0_inc", 32'(read_count), 32'd1);

    applyStimulus(1'b0, 1'b1, 2'd1, 1'b1, 2'd1, 1'b0);
    checkOutput("same_ch_max_count", 32'(read_count), 32'd3);
    checkOutput("same_ch_max_ovf", 32'(overflow), 32'd0);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0);
    checkOutput("rtr1_dec", 32'(read_count), 32'd2);

    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 2'd1, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 2'd2, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 2'd1, 1'b0);
    checkOutput("pre_rst_ovf", 32'(overflow), 32'd1);
    probe(2'd0);
    checkOutput("pre_rst_ch0", 32'(read_count), 32'd2);
    probe(2'd1);
    checkOutput("pre_rst_ch1", 32'(read_count), 32'd3);
    probe(2'd2);
    checkOutput("pre_rst_ch2", 32'(read_count), 32'd1);

    applyStimulus(1'b1, 1'b1, 2'd3, 1'b1, 2'd2, 1'b0);
    for (int c = 0; c < 4; c++) begin
      probe(2'(c));
      checkOutput($sformatf("mid_rst_ch%0d", c), 32'(read_count), 32'd0);
    end
    checkOutput("mid_rst_ovf", 32'(overflow), 32'd0);
    checkOutput("mid_rst_unf", 32'(underflow), 32'd0);
    checkOutput("mid_rst_pending", 32'(any_pending), 32'd0);

`ifdef RX_FLAGS_ARB_EN
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
    checkOutput("arb_valid", 32'(next_valid), 32'd1);
    checkOutput("arb_first", 32'(next_channel), 32'd0);
    next_ack = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    checkOutput("arb_after_ack1", 32'(next_channel), 32'd2);
    next_ack = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    checkOutput("arb_wrap", 32'(next_channel), 32'd0);
    checkOutput("arb_ack_no_count_change", 32'(read_count), 32'd1);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0);
    checkOutput("arb_idle_valid", 32'(next_valid), 32'd0);
    checkOutput("arb_idle_channel", 32'(next_channel), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
